// File: rtl/edge_generator.sv
// Request-driven edge generator: each accepted request produces one window with
// HIGH_CYCLES high and LOW_CYCLES low. Requests that arrive while a window runs are queued.
module edge_generator #(
    parameter int HIGH_CYCLES = 2,
    parameter int LOW_CYCLES  = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             clr_ovf,
    output logic             sig_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             done
);

    localparam int TMAX  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CNT_W-1:0] PMAX      = '1;
    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [TMR_W-1:0] timer, timer_next;
    logic [CNT_W-1:0] pending_next;
    logic             ovf_next;
    logic             sig_next;
    logic             done_next;

    logic start_slot;
    logic start;
    logic from_pend;
    logic bypass;
    logic accept;
    logic drop;

    // Saturating queue-depth update; neither wraps past PMAX nor goes below zero.
    function automatic logic [CNT_W-1:0] pend_update(input logic [CNT_W-1:0] cur,
                                                     input logic inc,
                                                     input logic dec);
        if (inc && !dec && cur != PMAX)
            return cur + CNT_W'(1);
        if (dec && !inc && cur != '0)
            return cur - CNT_W'(1);
        return cur;
    endfunction

    // A new window may only begin from IDLE or on the final LOW cycle.
    assign start_slot = (state == IDLE) || (state == LOW && timer == '0);
    assign start      = start_slot && (pending != '0 || pulse_in);
    assign from_pend  = start && (pending != '0);
    assign bypass     = start && !from_pend;
    assign accept     = pulse_in && !bypass && (pending != PMAX || from_pend);
    assign drop       = pulse_in && !bypass && !accept;

    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        timer_next = timer;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HIGH;
                    timer_next = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (timer == '0) begin
                    state_next = LOW;
                    timer_next = LOW_LOAD;
                end else begin
                    timer_next = timer - TMR_W'(1);
                end
            end
            LOW: begin
                if (timer == '0) begin
                    done_next = 1'b1;
                    if (start) begin
                        state_next = HIGH;
                        timer_next = HIGH_LOAD;
                    end else begin
                        state_next = IDLE;
                        timer_next = '0;
                    end
                end else begin
                    timer_next = timer - TMR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        sig_next     = (state_next == HIGH);
        pending_next = pend_update(pending, accept, from_pend);
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_next     = drop | (overflow & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            sig_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            pending  <= pending_next;
            overflow <= ovf_next;
            sig_out  <= sig_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: fixed vector table, hand-built corner sequences and
// randomized traffic compared against a window-position reference model.
module tb_edge_generator;

    localparam int H     = 2;
    localparam int L     = 2;
    localparam int CW    = 3;
    localparam int PMAX  = 7;
    localparam int NVEC  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pulse_in = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          sig_out;
    logic          busy;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Reference model: queued request count, position inside the current
    // high+low window (-1 when no window is running), sticky overflow, done.
    int m_pend;
    int m_t;
    int m_ovf;
    int m_done;

    typedef struct {
        logic pulse;
        logic sig;
        logic busy;
        int   pend;
        logic done;
    } vec_t;

    vec_t tbl[NVEC];

    edge_generator #(
        .HIGH_CYCLES(H),
        .LOW_CYCLES (L),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .clr_ovf (clr_ovf),
        .sig_out (sig_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0;
        m_t    = -1;
        m_ovf  = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input logic p, input logic c);
        int last;
        bit can;
        bit fp;
        bit byp;
        bit drp;
        last = H + L - 1;
        can  = ((m_t < 0) || (m_t == last)) && (m_pend > 0 || p);
        fp   = can && (m_pend > 0);
        byp  = can && !fp;
        drp  = 1'b0;
        m_done = (m_t == last) ? 1 : 0;
        if (p && !byp) begin
            if (m_pend < PMAX || fp) m_pend++;
            else drp = 1'b1;
        end
        if (fp) m_pend--;
        if (drp) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (can) m_t = 0;
        else if (m_t < 0 || m_t == last) m_t = -1;
        else m_t++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".sig"},  int'(sig_out),  (m_t >= 0 && m_t < H) ? 1 : 0);
        chk({tag, ".busy"}, int'(busy),     (m_t >= 0) ? 1 : 0);
        chk({tag, ".pend"}, int'(pending),  m_pend);
        chk({tag, ".done"}, int'(done),     m_done);
        chk({tag, ".ovf"},  int'(overflow), m_ovf);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next.
    task automatic step(input logic p, input logic c, input string tag);
        pulse_in = p;
        clr_ovf  = c;
        @(posedge clk);
        model_edge(p, c);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk({tag, ".async_sig"},  int'(sig_out),  0);
        chk({tag, ".async_busy"}, int'(busy),     0);
        chk({tag, ".async_pend"}, int'(pending),  0);
        chk({tag, ".async_done"}, int'(done),     0);
        chk({tag, ".async_ovf"},  int'(overflow), 0);
        pulse_in = 1'b1;
        clr_ovf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".held_sig"},  int'(sig_out), 0);
        chk({tag, ".held_pend"}, int'(pending), 0);
        pulse_in = 1'b0;
        rst_n    = 1'b1;
        model_reset();
    endtask

    task automatic set_vec(input int i, input logic p, input logic s, input logic b,
                           input int pd, input logic d);
        tbl[i].pulse = p;
        tbl[i].sig   = s;
        tbl[i].busy  = b;
        tbl[i].pend  = pd;
        tbl[i].done  = d;
    endtask

    initial begin
        int rises;
        int thr;
        logic prev;

        // Three back-to-back pulses, then a lone pulse from IDLE.
        set_vec( 0, 1, 1, 1, 0, 0);
        set_vec( 1, 1, 1, 1, 1, 0);
        set_vec( 2, 1, 0, 1, 2, 0);
        set_vec( 3, 0, 0, 1, 2, 0);
        set_vec( 4, 0, 1, 1, 1, 1);
        set_vec( 5, 0, 1, 1, 1, 0);
        set_vec( 6, 0, 0, 1, 1, 0);
        set_vec( 7, 0, 0, 1, 1, 0);
        set_vec( 8, 0, 1, 1, 0, 1);
        set_vec( 9, 0, 1, 1, 0, 0);
        set_vec(10, 0, 0, 1, 0, 0);
        set_vec(11, 0, 0, 1, 0, 0);
        set_vec(12, 0, 0, 0, 0, 1);
        set_vec(13, 0, 0, 0, 0, 0);
        set_vec(14, 1, 1, 1, 0, 0);
        set_vec(15, 0, 1, 1, 0, 0);
        set_vec(16, 0, 0, 1, 0, 0);
        set_vec(17, 0, 0, 1, 0, 0);
        set_vec(18, 0, 0, 0, 0, 1);
        set_vec(19, 0, 0, 0, 0, 0);

        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].pulse, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.sig_c", i),  int'(sig_out),  int'(tbl[i].sig));
            chk($sformatf("tbl%0d.busy_c", i), int'(busy),     int'(tbl[i].busy));
            chk($sformatf("tbl%0d.pend_c", i), int'(pending),  tbl[i].pend);
            chk($sformatf("tbl%0d.done_c", i), int'(done),     int'(tbl[i].done));
            chk($sformatf("tbl%0d.ovf_c", i),  int'(overflow), 0);
        end

        // pulse_in held for 12 edges: fills the queue and drops the last two.
        do_reset("fill");
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 52; i++) begin
            step((i < 12) ? 1'b1 : 1'b0, 1'b0, $sformatf("fill%0d", i));
            if (sig_out && !prev) rises++;
            prev = sig_out;
            if (i == 9) begin
                chk("fill.pend_at9", int'(pending), 7);
                chk("fill.ovf_at9", int'(overflow), 0);
            end
            if (i == 10) chk("fill.ovf_at10", int'(overflow), 1);
        end
        chk("fill.windows", rises, 10);
        chk("fill.busy_end", int'(busy), 0);
        chk("fill.ovf_end", int'(overflow), 1);

        // Full queue while LOW completes and a pulse arrives: accept and start together.
        do_reset("full");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $sformatf("full%0d", i));
        step(1'b0, 1'b0, "full10");
        step(1'b0, 1'b0, "full11");
        chk("full.pre_pend", int'(pending), 7);
        step(1'b1, 1'b0, "full12");
        chk("full.sig", int'(sig_out), 1);
        chk("full.pend", int'(pending), 7);
        chk("full.ovf", int'(overflow), 0);
        // Drop sets overflow; a drop alongside clr keeps it; clr alone clears it.
        step(1'b1, 1'b0, "ovf13");
        chk("ovf.set", int'(overflow), 1);
        step(1'b1, 1'b1, "ovf14");
        chk("ovf.set_wins", int'(overflow), 1);
        step(1'b0, 1'b1, "ovf15");
        chk("ovf.cleared", int'(overflow), 0);

        // Reset one cycle into HIGH with three requests queued.
        do_reset("mid");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $sformatf("mid%0d", i));
        step(1'b0, 1'b0, "mid5");
        chk("mid.pre_sig", int'(sig_out), 1);
        chk("mid.pre_pend", int'(pending), 3);
        do_reset("midrst");
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, $sformatf("quiet%0d", i));
            if (sig_out) rises++;
        end
        chk("mid.quiet_high_cycles", rises, 0);

        // Randomized traffic with varying request density.
        for (int blk = 0; blk < 6; blk++) begin
            thr = 15 + blk * 15;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                     $sformatf("rnd%0d_%0d", blk, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_generator.md
EDGE_GENERATOR -- requirements
Module: edge_generator

Interface
REQ-001 Parameter HIGH_CYCLES, default 2, number of clk cycles sig_out is held high per emitted edge; legal values are 1 and above.
REQ-002 Parameter LOW_CYCLES, default 2, minimum number of clk cycles sig_out is held low after each high window; legal values are 1 and above.
REQ-003 Parameter CNT_W, default 3, width of the pending-request counter; capacity is PMAX = 2^CNT_W - 1.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 pulse_in  input  1  request strobe; each cycle it is sampled high is one request.
REQ-007 clr_ovf  input  1  synchronous clear of overflow.
REQ-008 sig_out  output  1  registered, glitch-free edge output to the consumer domain.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 pending  output  CNT_W  requests accepted but not yet started.
REQ-011 overflow  output  1  sticky flag indicating a request was dropped.
REQ-012 done  output  1  one-cycle pulse at completion of each high plus low sequence.

Function
REQ-013 The FSM SHALL have three states: IDLE (sig_out=0), HIGH (sig_out=1) and LOW (sig_out=0).
REQ-014 A start event SHALL consume one request; it is sourced from pending when pending is non-zero, otherwise from pulse_in in the same cycle (bypass).
REQ-015 In IDLE, if pending!=0 or pulse_in=1, the FSM SHALL enter HIGH on the next edge; latency from pulse_in sampled at edge k is sig_out=1 after edge k.
REQ-016 In HIGH, sig_out SHALL remain 1 for exactly HIGH_CYCLES cycles, then the FSM SHALL enter LOW.
REQ-017 In LOW, sig_out SHALL remain 0 for exactly LOW_CYCLES cycles; on exit, a start event available per REQ-014 SHALL send the FSM to HIGH, otherwise it SHALL go to IDLE.
REQ-018 done SHALL be 1 for exactly the one cycle following the edge on which LOW completes, whether the next state is HIGH or IDLE.
REQ-019 Pending update rule: pending_next = pending + accept - start_from_pending, where a bypass start does not touch pending.
  - A simultaneous accept and start from pending leaves pending unchanged.
REQ-020 When pending == PMAX and pulse_in=1, the request SHALL be accepted only if a start from pending occurs in the same cycle.
  - Otherwise the request is dropped and overflow is set.
REQ-021 overflow SHALL be sticky and cleared only by clr_ovf=1 or reset.
  - clr_ovf in the same cycle as a new drop leaves overflow=1 (set wins).
REQ-022 pending SHALL never wrap; it saturates at PMAX and never underflows below 0.
REQ-023 The internal cycle timer SHALL be wide enough for max(HIGH_CYCLES, LOW_CYCLES).
  - It reloads on every state entry.
REQ-024 The emitted period SHALL be exactly HIGH_CYCLES+LOW_CYCLES for back-to-back requests, so each high window yields a distinct rising edge.
REQ-025 busy SHALL be 0 only in IDLE; done, overflow and pending are registered outputs.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force state=IDLE, sig_out=0, busy=0, done=0, pending=0, overflow=0 and timer=0, independent of clk.
REQ-027 A reset asserted mid-HIGH or mid-LOW SHALL discard all pending requests.
  - No edge is emitted after release unless a new pulse_in arrives.
REQ-028 pulse_in SHALL be ignored during reset; the first edge after release samples normally.

Verification (defaults: H=2, L=2, PMAX=7)
REQ-029 Single pulse at edge 0 from IDLE -> sig_out=1 after edges 0-1, 0 after edges 2-3, done=1 after edge 4 only, busy=0 after edge 4, pending=0 throughout.
REQ-030 Three pulses on consecutive edges 0-2 -> three high windows starting at edges 0, 4 and 8; pending sequence 0,1,2,2,1,1,1,1,0; final done after edge 12.
REQ-031 pulse_in held high for 12 edges (0-11) from IDLE -> starts at edges 0, 4 and 8; pending reaches 7 at edge 9; drops at edges 10 and 11; overflow=1; 10 high windows in total.
REQ-032 pending=7, LOW completing, and pulse_in=1 in the same cycle -> HIGH entered, pending stays 7, overflow stays 0.
REQ-033 overflow=1 with clr_ovf=1 and a drop in the same cycle -> overflow remains 1; clr_ovf alone on the next cycle -> overflow=0.
REQ-034 rst_n asserted one cycle into HIGH with pending=3 -> sig_out, pending and busy go to 0 asynchronously; no sig_out activity in the 20 cycles after release.
